// File: rtl/ctrl_pkg.sv
// Shared definitions for the R-type sequencer: FSM states, funct and ALU
// operation codes, and the bit positions of the instruction fields.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;
    localparam int unsigned FN_MSB = 5;
    localparam int unsigned FN_LSB = 0;

endpackage

// File: rtl/ctrl_tipo_r_funct_dec.sv
// Combinational funct -> ALU operation decoder with a legal-funct flag.
// Unsupported funct values decode to ALU_AND (4'b0000) with legal low.
module funct_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_AND;
        legal  = 1'b1;
        case (funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            FUNCT_NOR: alu_op = ALU_NOR;
            FUNCT_SLT: alu_op = ALU_SLT;
            default:   legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_tipo_r.sv
// Multicycle R-type sequencer: IDLE -> DECODE -> EXEC -> WB, one instruction
// per four cycles, driving bank read/write addresses, ALU select and RegEn.
module ctrl_tipo_r
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter logic [5:0]  OPC_RTYPE = 6'b000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       R_register_1,
    output logic [4:0]       R_register_2,
    output logic [4:0]       W_register,
    output logic             RegEn,
    output logic [3:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state_q, state_d;

    logic [31:0]      ir_q;
    logic [3:0]       alu_op_q;
    logic             funct_ok_q;
    logic [4:0]       w_reg_q;
    logic             reg_en_q;
    logic             done_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic [3:0] dec_alu_op;
    logic       dec_legal;
    logic       accept;
    logic       ex_legal;
    logic       unused_ir;

    funct_dec u_funct_dec (
        .funct  (instr[FN_MSB:FN_LSB]),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    assign accept   = (state_q == IDLE) && instr_valid;
    assign ex_legal = (ir_q[OP_MSB:OP_LSB] == OPC_RTYPE) && funct_ok_q;
    // funct is decoded straight off the bus at accept; shamt is never needed
    assign unused_ir = ^ir_q[10:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode results are registered on the accept edge so they are already
    // valid during DECODE; write-back outputs are registered on entry to WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= '0;
            alu_op_q   <= '0;
            funct_ok_q <= 1'b0;
            w_reg_q    <= '0;
            reg_en_q   <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            reg_en_q <= 1'b0;
            done_q   <= 1'b0;
            if (accept) begin
                ir_q       <= instr;
                alu_op_q   <= dec_alu_op;
                funct_ok_q <= dec_legal;
            end
            if (state_q == EXEC) begin
                w_reg_q  <= ir_q[RD_MSB:RD_LSB];
                done_q   <= 1'b1;
                reg_en_q <= ex_legal && (ir_q[RD_MSB:RD_LSB] != 5'd0);
                if (ex_legal) begin
                    retired_q <= retired_q + CNT_W'(1);
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign instr_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign R_register_1 = ir_q[RS_MSB:RS_LSB];
    assign R_register_2 = ir_q[RT_MSB:RT_LSB];
    assign W_register   = w_reg_q;
    assign RegEn        = reg_en_q;
    assign alu_op       = alu_op_q;
    assign done         = done_q;
    assign illegal      = illegal_q;
    assign retired      = retired_q;

endmodule
